// File: rtl/bounce_pkg.sv
// Shared types and defaults for the bouncing-object engine.
package bounce_pkg;

  localparam int COORD_W   = 10;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x_pos;
    coord_t y_pos;
  } obj_pos_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Power-on placement: objects staggered diagonally so they start apart.
  function automatic obj_pos_t reset_pos(input int idx);
    obj_pos_t p;
    p.x_pos = COORD_W'(40 + 60 * idx);
    p.y_pos = COORD_W'(40 + 40 * idx);
    return p;
  endfunction

endpackage

// File: rtl/bounce_if.sv
// Video-side bus of the bounce engine: sync/control in, per-object flags out.
interface bounce_if #(
  parameter int NUM_OBJ = 4,
  parameter int SPEED_W = 3
);
  import bounce_pkg::*;

  logic                       vsync_i;
  logic                       pause_i;
  logic [NUM_OBJ*SPEED_W-1:0] speed_i;
  coord_t                     pixel_x_i;
  coord_t                     pixel_y_i;
  logic [NUM_OBJ-1:0]         obj_on_o;
  logic [NUM_OBJ-1:0]         bounce_o;
  logic                       frame_done_o;
  logic [15:0]                frame_cnt_o;

  modport master (
    output vsync_i, pause_i, speed_i, pixel_x_i, pixel_y_i,
    input  obj_on_o, bounce_o, frame_done_o, frame_cnt_o
  );

  modport slave (
    input  vsync_i, pause_i, speed_i, pixel_x_i, pixel_y_i,
    output obj_on_o, bounce_o, frame_done_o, frame_cnt_o
  );

endinterface

// File: rtl/bounce_axis.sv
// One-axis motion step: advance by speed or reverse at the edge of the field.
module bounce_axis
  import bounce_pkg::*;
#(
  parameter int OBJ_SIZE = 20,
  parameter int SPEED_W  = 3
) (
  input  coord_t             pos_i,
  input  logic               dir_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  coord_t             limit_i,
  output coord_t             pos_o,
  output logic               dir_o,
  output logic               bounce_o
);

  coord_t speed_s;
  coord_t hi_lim_s;

  assign speed_s  = COORD_W'(speed_i);
  // Highest start position from which a full step still keeps the object on screen.
  assign hi_lim_s = limit_i - COORD_W'(OBJ_SIZE) - speed_s;

  // Step toward the current direction; when the step would leave the field, hold and reverse.
  always_comb begin
    pos_o    = pos_i;
    dir_o    = dir_i;
    bounce_o = 1'b0;
    if (dir_i) begin
      if (pos_i < hi_lim_s) begin
        pos_o = pos_i + speed_s;
      end else begin
        dir_o    = 1'b0;
        bounce_o = 1'b1;
      end
    end else begin
      if (pos_i >= speed_s) begin
        pos_o = pos_i - speed_s;
      end else begin
        dir_o    = 1'b1;
        bounce_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bounce_engine.sv
// Moves NUM_OBJ square objects once per frame, one object per clock, and
// reports per-pixel coverage, reversals and completed passes.
module bounce_engine
  import bounce_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_SIZE = 20,
  parameter int SPEED_W  = 3,
  parameter int H_ACT    = H_ACT_DEF,
  parameter int V_ACT    = V_ACT_DEF
) (
  input logic       clk,
  input logic       rst_n,
  bounce_if.slave   bus
);

  localparam int               IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam coord_t           H_LIM    = COORD_W'(H_ACT);
  localparam coord_t           V_LIM    = COORD_W'(V_ACT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vsync_q;
  obj_pos_t           pos_q [NUM_OBJ];
  logic [NUM_OBJ-1:0] dir_x_q, dir_y_q;
  logic [NUM_OBJ-1:0] bounce_q, bounce_d;
  logic               frame_done_q;
  logic [15:0]        frame_cnt_q;

  logic               frame_ev_s;
  logic               upd_en_s;
  logic               pass_end_s;
  logic [SPEED_W-1:0] speed_s [NUM_OBJ];
  obj_pos_t           cur_pos_s;
  logic               cur_dx_s, cur_dy_s;
  logic [SPEED_W-1:0] cur_speed_s;
  coord_t             nxt_x_s, nxt_y_s;
  logic               nxt_dx_s, nxt_dy_s;
  logic               bounce_x_s, bounce_y_s;
  logic [NUM_OBJ-1:0] obj_on_s;

  // Falling edge of vsync marks the start of vertical blanking.
  assign frame_ev_s = vsync_q & ~bus.vsync_i;

  // Split the packed speed bus into one field per object.
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      speed_s[i] = bus.speed_i[i*SPEED_W +: SPEED_W];
    end
  end

  assign cur_pos_s   = pos_q[idx_q];
  assign cur_dx_s    = dir_x_q[idx_q];
  assign cur_dy_s    = dir_y_q[idx_q];
  assign cur_speed_s = speed_s[idx_q];

  bounce_axis #(.OBJ_SIZE(OBJ_SIZE), .SPEED_W(SPEED_W)) u_axis_x (
    .pos_i    (cur_pos_s.x_pos),
    .dir_i    (cur_dx_s),
    .speed_i  (cur_speed_s),
    .limit_i  (H_LIM),
    .pos_o    (nxt_x_s),
    .dir_o    (nxt_dx_s),
    .bounce_o (bounce_x_s)
  );

  bounce_axis #(.OBJ_SIZE(OBJ_SIZE), .SPEED_W(SPEED_W)) u_axis_y (
    .pos_i    (cur_pos_s.y_pos),
    .dir_i    (cur_dy_s),
    .speed_i  (cur_speed_s),
    .limit_i  (V_LIM),
    .pos_o    (nxt_y_s),
    .dir_o    (nxt_dy_s),
    .bounce_o (bounce_y_s)
  );

  // Pass sequencing: wait for a frame event, walk the objects, then flag completion.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    upd_en_s   = 1'b0;
    pass_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_ev_s && !bus.pause_i) begin
          state_d = UPDATE;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      UPDATE: begin
        upd_en_s = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d    = DONE;
          idx_d      = '0;
          pass_end_s = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Reversal of either axis gives a single pulse for the object being moved.
  always_comb begin
    bounce_d = '0;
    if (upd_en_s) begin
      bounce_d[idx_q] = bounce_x_s | bounce_y_s;
    end else begin
      bounce_d = '0;
    end
  end

  // Coverage test per object; 11-bit sums keep the right/bottom edge exact.
  always_comb begin
    obj_on_s = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_on_s[i] =
        (bus.pixel_x_i >= pos_q[i].x_pos) &&
        ({1'b0, bus.pixel_x_i} < ({1'b0, pos_q[i].x_pos} + 11'(OBJ_SIZE))) &&
        (bus.pixel_y_i >= pos_q[i].y_pos) &&
        ({1'b0, bus.pixel_y_i} < ({1'b0, pos_q[i].y_pos} + 11'(OBJ_SIZE)));
    end
  end

  // FSM state, object index and vsync history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= bus.vsync_i;
    end
  end

  // Object positions and directions; only the indexed object changes per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_q[i]   <= reset_pos(i);
        dir_x_q[i] <= i[0];
        dir_y_q[i] <= i[0];
      end
    end else if (upd_en_s) begin
      pos_q[idx_q].x_pos <= nxt_x_s;
      pos_q[idx_q].y_pos <= nxt_y_s;
      dir_x_q[idx_q]     <= nxt_dx_s;
      dir_y_q[idx_q]     <= nxt_dy_s;
    end
  end

  // Registered status outputs: bounce pulses, pass-done pulse and pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bounce_q     <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      bounce_q     <= bounce_d;
      frame_done_q <= pass_end_s;
      if (pass_end_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign bus.obj_on_o     = obj_on_s;
  assign bus.bounce_o     = bounce_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_bounce_engine.sv
// Self-checking bench for bounce_engine: behavioural model plus directed probes
// followed by randomized frames, speeds, pauses and pixels.
module tb_bounce_engine;
  import bounce_pkg::*;

  localparam int N  = 4;
  localparam int OS = 20;
  localparam int SW = 3;
  localparam int H  = 640;
  localparam int V  = 480;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bounce_if #(.NUM_OBJ(N), .SPEED_W(SW)) bif ();

  bounce_engine #(
    .NUM_OBJ(N), .OBJ_SIZE(OS), .SPEED_W(SW), .H_ACT(H), .V_ACT(V)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: object positions and a pass schedule counter.
  int        mx [N];
  int        my [N];
  bit        mdx [N];
  bit        mdy [N];
  int        busy;
  int        nxt;
  bit        prev_vs;
  bit [N-1:0] exp_bounce;
  bit        exp_done;
  int        exp_cnt;
  int        m_spd, m_px, m_py;
  bit        m_dx, m_dy, m_bx, m_by, m_ev;

  // Literal expectations posted by the stimulus process, consumed by the compare process.
  string lit_name;
  int    lit_act, lit_exp;
  int    lit_post = 0;
  int    lit_seen = 0;

  function automatic void step_axis(input int p, input bit d, input int spd, input int ext,
                                    output int np, output bit nd, output bit b);
    np = p; nd = d; b = 1'b0;
    if (d) begin
      if (p < ext - OS - spd) np = p + spd;
      else begin nd = 1'b0; b = 1'b1; end
    end else begin
      if (p >= spd) np = p - spd;
      else begin nd = 1'b1; b = 1'b1; end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = 40 + 60 * i;
        my[i] = 40 + 40 * i;
        mdx[i] = (i % 2) == 1;
        mdy[i] = (i % 2) == 1;
      end
      busy = 0; nxt = 0; prev_vs = 1'b0;
      exp_bounce = '0; exp_done = 1'b0; exp_cnt = 0;
    end else begin
      m_ev = prev_vs && !bif.vsync_i;
      prev_vs = bif.vsync_i;
      exp_bounce = '0;
      exp_done = 1'b0;
      if (busy == 0) begin
        if (m_ev && !bif.pause_i) begin
          busy = N + 1;
          nxt = 0;
        end
      end else if (busy == 1) begin
        busy = 0;
      end else begin
        m_spd = int'((bif.speed_i >> (nxt * SW)) & 12'h007);
        step_axis(mx[nxt], mdx[nxt], m_spd, H, m_px, m_dx, m_bx);
        step_axis(my[nxt], mdy[nxt], m_spd, V, m_py, m_dy, m_by);
        mx[nxt] = m_px; mdx[nxt] = m_dx;
        my[nxt] = m_py; mdy[nxt] = m_dy;
        exp_bounce[nxt] = m_bx | m_by;
        nxt++;
        busy--;
        if (nxt == N) begin
          exp_done = 1'b1;
          exp_cnt = (exp_cnt + 1) % 65536;
        end
      end
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  bit [N-1:0] exp_on;
  int         c_px, c_py;

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    #2;
    c_px = int'(bif.pixel_x_i);
    c_py = int'(bif.pixel_y_i);
    exp_on = '0;
    for (int i = 0; i < N; i++) begin
      exp_on[i] = (c_px >= mx[i]) && (c_px < mx[i] + OS) && (c_py >= my[i]) && (c_py < my[i] + OS);
    end
    chk("obj_on", int'(bif.obj_on_o), int'(exp_on));
    chk("bounce", int'(bif.bounce_o), int'(exp_bounce));
    chk("frame_done", int'(bif.frame_done_o), int'(exp_done));
    chk("frame_cnt", int'(bif.frame_cnt_o), exp_cnt);
    if (lit_post != lit_seen) begin
      lit_seen = lit_post;
      chk(lit_name, lit_act, lit_exp);
    end
  end

  task automatic post(input string nm, input int act, input int exp);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = exp;
    lit_post++;
    @(negedge clk);
    #3;
  endtask

  task automatic cyc();
    int k;
    @(negedge clk);
    k = $urandom_range(0, N - 1);
    bif.pixel_x_i = COORD_W'(mx[k] + int'($urandom_range(0, OS + 1)) - 1);
    bif.pixel_y_i = COORD_W'(my[k] + int'($urandom_range(0, OS + 1)) - 1);
  endtask

  task automatic probe(input int px, input int py, input int mask, input int exp, input string nm);
    @(negedge clk);
    bif.pixel_x_i = COORD_W'(px);
    bif.pixel_y_i = COORD_W'(py);
    #3;
    post(nm, int'(bif.obj_on_o) & mask, exp);
  endtask

  task automatic run_frame(output bit [N-1:0] bseen, output int lat);
    bit got;
    bseen = '0; got = 1'b0; lat = 0;
    cyc(); bif.vsync_i = 1'b1;
    cyc(); bif.vsync_i = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      cyc();
      #3;
      bseen |= bif.bounce_o;
      if (bif.frame_done_o) begin
        got = 1'b1;
        lat = n + 1;
      end
    end
    if (!got) post("frame_done_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of stimulus, expected finish before 1 ms");
    $fatal(1);
  end

  bit [N-1:0] b;
  int         lat;
  int         ndone;

  initial begin
    bif.vsync_i   = 1'b0;
    bif.pause_i   = 1'b0;
    bif.speed_i   = '0;
    bif.pixel_x_i = '0;
    bif.pixel_y_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset placement and coverage.
    post("cnt_reset", int'(bif.frame_cnt_o), 0);
    probe(40, 40, 15, 1, "on_40_40");
    probe(60, 40, 15, 0, "on_60_40");
    probe(100, 80, 15, 2, "on_100_80");

    // First pass with all speeds 2.
    bif.speed_i = {N{3'd2}};
    run_frame(b, lat);
    post("done_latency", lat, N + 1);
    post("cnt_after_1", int'(bif.frame_cnt_o), 1);
    probe(38, 38, 1, 1, "obj0_38_38");
    probe(37, 38, 1, 0, "obj0_left_edge");
    probe(102, 82, 2, 2, "obj1_102_82");
    probe(102, 81, 2, 0, "obj1_top_edge");

    // Obj1 reaches the bottom at pass 190.
    for (int f = 2; f <= 189; f++) run_frame(b, lat);
    run_frame(b, lat);
    post("obj1_ybounce", int'(b[1]), 1);
    post("obj0_no_bounce_190", int'(b[0]), 0);
    run_frame(b, lat);
    probe(482, 456, 2, 2, "obj1_482_456");
    probe(481, 456, 2, 0, "obj1_xdir_kept");
    probe(482, 455, 2, 0, "obj1_y_up");

    // Obj0 reaches the right edge at X=618 after pass 330.
    for (int f = 192; f <= 330; f++) run_frame(b, lat);
    probe(618, 300, 1, 1, "obj0_618_300");
    probe(617, 300, 1, 0, "obj0_x618_edge");
    run_frame(b, lat);
    post("obj0_xbounce", int'(b[0]), 1);
    probe(618, 298, 1, 1, "obj0_held_618");
    run_frame(b, lat);
    probe(616, 296, 1, 1, "obj0_616_296");
    probe(636, 296, 1, 0, "obj0_right_edge");
    post("cnt_after_332", int'(bif.frame_cnt_o), 332);

    // Paused frames change nothing.
    bif.pause_i = 1'b1;
    repeat (3) begin
      cyc(); bif.vsync_i = 1'b1;
      cyc(); bif.vsync_i = 1'b0;
      repeat (6) cyc();
    end
    post("cnt_paused", int'(bif.frame_cnt_o), 332);
    probe(616, 296, 1, 1, "obj0_paused");
    bif.pause_i = 1'b0;

    // A second vsync fall during the pass is ignored.
    ndone = 0;
    cyc(); bif.vsync_i = 1'b1;
    cyc(); bif.vsync_i = 1'b0;
    cyc(); bif.vsync_i = 1'b1;
    cyc(); bif.vsync_i = 1'b0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      #3;
      if (bif.frame_done_o) ndone++;
    end
    post("single_done", ndone, 1);
    post("cnt_after_333", int'(bif.frame_cnt_o), 333);
    probe(614, 294, 1, 1, "obj0_614_294");

    // Reset while object 2 is being updated abandons the pass.
    cyc(); bif.vsync_i = 1'b1;
    cyc(); bif.vsync_i = 1'b0;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      #3;
      if (bif.frame_done_o) ndone++;
    end
    post("no_done_after_reset", ndone, 0);
    post("cnt_after_reset", int'(bif.frame_cnt_o), 0);
    probe(40, 40, 1, 1, "obj0_reset");
    probe(100, 80, 2, 2, "obj1_reset");
    probe(160, 120, 4, 4, "obj2_reset");
    probe(220, 160, 8, 8, "obj3_reset");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if ($urandom_range(0, 4) == 0) bif.vsync_i = ~bif.vsync_i;
      bif.pause_i = ($urandom_range(0, 4) == 0);
      bif.speed_i = (N * SW)'($urandom);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
    end
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bounce_engine.md
BOUNCE_ENGINE -- requirements
Module: bounce_engine

Interface
REQ-001 Parameter NUM_OBJ, default 4, number of independent objects (legal 1..8).
REQ-002 Parameter OBJ_SIZE, default 20, square object edge in pixels.
REQ-003 Parameter SPEED_W, default 3, per-object speed width (legal 1..5).
REQ-004 Parameter H_ACT, default 640; V_ACT, default 480; active display extents.
REQ-005 Clock  in  1  pixel clock; all state on rising edge.
REQ-006 Resetn  in  1  asynchronous, active-low reset.
REQ-007 vsync_i  in  1  VGA vertical sync from the VGA controller.
REQ-008 pause_i  in  1  high: frame updates suppressed.
REQ-009 speed_i  in  NUM_OBJ*SPEED_W  speed of object i at bits [i*SPEED_W +: SPEED_W].
REQ-010 pixel_x_i, pixel_y_i  in  10 each  current scan coordinate.
REQ-011 obj_on_o  out  NUM_OBJ  bit i high when the pixel lies inside object i.
REQ-012 bounce_o  out  NUM_OBJ  bit i one-cycle pulse when object i reverses any direction.
REQ-013 frame_done_o  out  1  one-cycle pulse at the end of each update pass.
REQ-014 frame_cnt_o  out  16  completed update passes, wraps 0xFFFF->0.

Function
REQ-015 The block SHALL register vsync_i and detect a frame event as registered-high AND current-low.
REQ-016 FSM states SHALL be IDLE, UPDATE, DONE; IDLE->UPDATE on a frame event with pause_i low, else stay IDLE.
REQ-017 In UPDATE, the object index SHALL advance 0..NUM_OBJ-1, one object per cycle; after index NUM_OBJ-1 -> DONE.
REQ-018 DONE SHALL last one cycle: frame_done_o=1, frame_cnt_o+1, ->IDLE.
REQ-019 Frame events in UPDATE or DONE SHALL be ignored; pause_i is sampled only in IDLE.
REQ-020 X moving right (dir 1): if X < H_ACT-OBJ_SIZE-speed then X+=speed, else X unchanged, X dir<=0, bounce pulse.
REQ-021 X moving left (dir 0): if X >= speed then X-=speed, else X unchanged, X dir<=1, bounce pulse.
REQ-022 Y SHALL follow REQ-020/021 using V_ACT and its own Y dir; a Y limit SHALL never modify the X dir.
REQ-023 Both axes of one object update in the same cycle; a double reversal gives a single bounce pulse.
REQ-024 Speed SHALL be sampled in the object's own update cycle; speed 0 leaves position unchanged without bouncing.
REQ-025 Comparisons SHALL be unsigned 10-bit; OBJ_SIZE+2^SPEED_W < V_ACT guarantees no underflow.
REQ-026 obj_on_o[i] SHALL be combinational: X<=px<X+OBJ_SIZE and Y<=py<Y+OBJ_SIZE.
REQ-027 Objects SHALL not interact; overlapping objects both assert obj_on_o.

Reset
REQ-028 Resetn low SHALL force FSM IDLE, index 0, vsync register 0, bounce_o 0, frame_done_o 0, frame_cnt_o 0.
REQ-029 Object i SHALL reset to X=40+60*i, Y=40+40*i, X dir = Y dir = i[0].
REQ-030 Reset asserted mid-UPDATE SHALL abandon the pass; no frame_done_o pulse follows.

Structure
REQ-031 Package bounce_pkg SHALL hold the coordinate typedef (10-bit X_pos, Y_pos), the FSM state enum, and the H_ACT/V_ACT defaults.
REQ-032 A combinational sub-module bounce_axis (position, dir, speed, limit -> next position, next dir, bounce) SHALL be instantiated once per axis.

Verification
REQ-033 Reset, pixel (40,40) -> obj_on_o=0001; pixel (60,40) -> 0000; pixel (100,80) -> 0010.
REQ-034 All speeds 2, one vsync fall -> obj0 at (38,38), obj1 at (102,82), frame_done_o one cycle after the last update, frame_cnt_o=1.
REQ-035 Obj0 X=618 dir right, speed 2, frame -> X stays 618, dir left, bounce_o[0] pulse; next frame X=616.
REQ-036 Obj1 Y at bottom limit, moving down -> Y dir flips; X dir unchanged.
REQ-037 pause_i high across 3 vsync falls -> positions and frame_cnt_o frozen; second vsync fall during UPDATE -> ignored.
REQ-038 Resetn low during UPDATE index 2 -> all objects at reset positions, no frame_done_o pulse.
